// File: rtl/decode_stage.sv
// decode_stage: registered MIPS instruction decoder between fetch and execute.
// Each accepted instruction word becomes a registered control bundle. A small
// countdown tracks how long the multiply/divide unit stays occupied, and
// HI/LO-touching instructions are held off while it is busy.
//
// Handshake (both sides): a transfer happens on a rising clock edge when
// valid and ready are both high. The producer holds valid and data steady
// until the transfer. Ready may depend combinationally on the offered data.
// Valid never depends on ready. out_valid and the bundle come straight from
// registers. in_ready is combinational from out_valid, out_ready, md_busy
// and in_instr.
module decode_stage #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        branch_jump,
    output logic [2:0]  npc_sel,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  wa_sel,
    output logic [1:0]  wd_sel,
    output logic [1:0]  md_start,
    output logic        illegal,
    output logic        md_busy
);

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;

    // Field encodings
    localparam logic [2:0] NPC_PC4    = 3'd0;
    localparam logic [2:0] NPC_BRANCH = 3'd1;
    localparam logic [2:0] NPC_JUMP   = 3'd2;
    localparam logic [2:0] NPC_JREG   = 3'd3;

    localparam logic [1:0] WA_RT   = 2'd0;
    localparam logic [1:0] WA_RD   = 2'd1;
    localparam logic [1:0] WA_R31  = 2'd2;

    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_MEM  = 2'd1;
    localparam logic [1:0] WD_PC8  = 2'd2;
    localparam logic [1:0] WD_HILO = 2'd3;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    // Busy-counter reload values (legal range keeps them within 8 bits)
    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES);

    // Control bundle carried to the execute stage
    typedef struct packed {
        logic       branch_jump;
        logic [2:0] npc_sel;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] wa_sel;
        logic [1:0] wd_sel;
        logic [1:0] md_start;
        logic       illegal;
    } ctrl_t;

    logic [5:0] opcode;
    logic [5:0] funct;
    ctrl_t      dec_ctrl;
    logic       dec_hilo;

    logic        hazard;
    logic        accept;

    logic        valid_q,    valid_d;
    ctrl_t       ctrl_q,     ctrl_d;
    logic [31:0] instr_q,    instr_d;
    logic [7:0]  busy_cnt_q, busy_cnt_d;

    assign opcode = in_instr[31:26];
    assign funct  = in_instr[5:0];

    // Combinational decode of the offered word; anything outside the
    // supported set yields an all-zero bundle with only illegal set.
    always_comb begin
        dec_ctrl = '0;
        dec_hilo = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR: begin
                        dec_ctrl.reg_write = 1'b1;
                        dec_ctrl.wa_sel    = WA_RD;
                        dec_ctrl.wd_sel    = WD_ALU;
                    end
                    FN_JR: begin
                        dec_ctrl.branch_jump = 1'b1;
                        dec_ctrl.npc_sel     = NPC_JREG;
                    end
                    FN_JALR: begin
                        dec_ctrl.branch_jump = 1'b1;
                        dec_ctrl.npc_sel     = NPC_JREG;
                        dec_ctrl.reg_write   = 1'b1;
                        dec_ctrl.wa_sel      = WA_RD;
                        dec_ctrl.wd_sel      = WD_PC8;
                    end
                    FN_MULT: begin
                        dec_ctrl.md_start = MD_MULT;
                        dec_hilo          = 1'b1;
                    end
                    FN_DIV: begin
                        dec_ctrl.md_start = MD_DIV;
                        dec_hilo          = 1'b1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        dec_ctrl.reg_write = 1'b1;
                        dec_ctrl.wa_sel    = WA_RD;
                        dec_ctrl.wd_sel    = WD_HILO;
                        dec_hilo           = 1'b1;
                    end
                    default: begin
                        dec_ctrl.illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.mem_read  = 1'b1;
                dec_ctrl.wa_sel    = WA_RT;
                dec_ctrl.wd_sel    = WD_MEM;
            end
            OP_SW: begin
                dec_ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec_ctrl.branch_jump = 1'b1;
                dec_ctrl.npc_sel     = NPC_BRANCH;
            end
            OP_J: begin
                dec_ctrl.branch_jump = 1'b1;
                dec_ctrl.npc_sel     = NPC_JUMP;
            end
            OP_JAL: begin
                dec_ctrl.branch_jump = 1'b1;
                dec_ctrl.npc_sel     = NPC_JUMP;
                dec_ctrl.reg_write   = 1'b1;
                dec_ctrl.wa_sel      = WA_R31;
                dec_ctrl.wd_sel      = WD_PC8;
            end
            default: begin
                dec_ctrl.illegal = 1'b1;
            end
        endcase
    end

    // A HI/LO user must wait while the multiply/divide unit is occupied;
    // everything else keeps flowing.
    assign md_busy  = (busy_cnt_q != 8'd0);
    assign hazard   = md_busy & dec_hilo;
    assign in_ready = (~valid_q | out_ready) & ~hazard;
    assign accept   = in_valid & in_ready;

    // Next-state for the output register: load on accept, drain when consumed,
    // otherwise hold so the bundle stays stable under back-pressure.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        instr_d = instr_q;
        if (accept) begin
            valid_d = 1'b1;
            ctrl_d  = dec_ctrl;
            instr_d = in_instr;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Busy countdown: a new mult/div reload wins over the decrement. The
    // hazard rule guarantees a reload only happens once the count is zero.
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (accept && dec_ctrl.md_start == MD_MULT) begin
            busy_cnt_d = MULT_LOAD;
        end else if (accept && dec_ctrl.md_start == MD_DIV) begin
            busy_cnt_d = DIV_LOAD;
        end else if (busy_cnt_q != 8'd0) begin
            busy_cnt_d = busy_cnt_q - 8'd1;
        end
    end

    // State registers; reset clears the bundle and drops any pending stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            instr_q    <= 32'd0;
            busy_cnt_q <= 8'd0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            instr_q    <= instr_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_instr   = instr_q;
    assign branch_jump = ctrl_q.branch_jump;
    assign npc_sel     = ctrl_q.npc_sel;
    assign reg_write   = ctrl_q.reg_write;
    assign mem_read    = ctrl_q.mem_read;
    assign mem_write   = ctrl_q.mem_write;
    assign wa_sel      = ctrl_q.wa_sel;
    assign wd_sel      = ctrl_q.wd_sel;
    assign md_start    = ctrl_q.md_start;
    assign illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic compared against a mnemonic-level reference model.
module tb_decode_stage;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        branch_jump;
  logic [2:0]  npc_sel;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  wa_sel;
  logic [1:0]  wd_sel;
  logic [1:0]  md_start;
  logic        illegal;
  logic        md_busy;

  decode_stage #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .branch_jump(branch_jump), .npc_sel(npc_sel), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .wa_sel(wa_sel),
    .wd_sel(wd_sel), .md_start(md_start), .illegal(illegal), .md_busy(md_busy)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef enum {M_ADDU, M_SUBU, M_AND, M_OR, M_JR, M_JALR, M_MULT, M_DIV,
                M_MFHI, M_MFLO, M_LW, M_SW, M_BEQ, M_J, M_JAL, M_BAD} mnem_t;

  // {branch_jump, npc_sel, reg_write, mem_read, mem_write, wa_sel, wd_sel, md_start, illegal}
  typedef struct packed {
    logic       bj;
    logic [2:0] npc;
    logic       rw;
    logic       mr;
    logic       mw;
    logic [1:0] wa;
    logic [1:0] wd;
    logic [1:0] md;
    logic       ill;
  } exp_t;

  function automatic mnem_t classify(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h21: return M_ADDU;
        6'h23: return M_SUBU;
        6'h24: return M_AND;
        6'h25: return M_OR;
        6'h08: return M_JR;
        6'h09: return M_JALR;
        6'h18: return M_MULT;
        6'h1a: return M_DIV;
        6'h10: return M_MFHI;
        6'h12: return M_MFLO;
        default: return M_BAD;
      endcase
    end
    case (op)
      6'h23: return M_LW;
      6'h2b: return M_SW;
      6'h04: return M_BEQ;
      6'h02: return M_J;
      6'h03: return M_JAL;
      default: return M_BAD;
    endcase
  endfunction

  // Each output field expressed as "which mnemonics produce which value".
  function automatic exp_t expect_ctrl(input mnem_t m);
    exp_t e;
    e.bj  = m inside {M_BEQ, M_J, M_JAL, M_JR, M_JALR};
    e.npc = (m == M_BEQ) ? 3'd1 : (m inside {M_J, M_JAL}) ? 3'd2 :
            (m inside {M_JR, M_JALR}) ? 3'd3 : 3'd0;
    e.rw  = m inside {M_ADDU, M_SUBU, M_AND, M_OR, M_MFHI, M_MFLO, M_LW, M_JAL, M_JALR};
    e.mr  = (m == M_LW);
    e.mw  = (m == M_SW);
    e.wa  = (m == M_JAL) ? 2'd2 :
            (m inside {M_ADDU, M_SUBU, M_AND, M_OR, M_MFHI, M_MFLO, M_JALR}) ? 2'd1 : 2'd0;
    e.wd  = (m == M_LW) ? 2'd1 : (m inside {M_JAL, M_JALR}) ? 2'd2 :
            (m inside {M_MFHI, M_MFLO}) ? 2'd3 : 2'd0;
    e.md  = (m == M_MULT) ? 2'b01 : (m == M_DIV) ? 2'b10 : 2'b00;
    e.ill = (m == M_BAD);
    return e;
  endfunction

  // Model state: what execute should currently see, and cycles of md occupancy left.
  logic        m_valid = 1'b0;
  exp_t        m_ctrl  = '0;
  logic [31:0] m_instr = 32'd0;
  int          m_busy_left = 0;
  logic        last_acc = 1'b0;
  logic        obs_ready = 1'b0;

  function automatic exp_t dut_ctrl();
    return {branch_jump, npc_sel, reg_write, mem_read, mem_write, wa_sel, wd_sel, md_start, illegal};
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge: drives one cycle of inputs, checks the
  // stage's readiness and, after the edge, its registered outputs.
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy);
    mnem_t m;
    logic  exp_ready;
    logic  acc;
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    m = classify(ins);
    @(negedge clk);
    exp_ready = (!m_valid || ordy) &&
                !(m_busy_left > 0 && (m inside {M_MULT, M_DIV, M_MFHI, M_MFLO}));
    obs_ready = in_ready;
    checks++;
    if (in_ready !== exp_ready) begin
      errors++;
      $display("FAIL in_ready instr=%08h got %0b want %0b", ins, in_ready, exp_ready);
    end
    acc = v && exp_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      m_valid = 1'b1;
      m_ctrl  = expect_ctrl(m);
      m_instr = ins;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    if (acc && m == M_MULT)     m_busy_left = MULT_N;
    else if (acc && m == M_DIV) m_busy_left = DIV_N;
    else if (m_busy_left > 0)   m_busy_left--;
    last_acc = acc;
    checks++;
    if (out_valid !== m_valid) begin
      errors++;
      $display("FAIL out_valid got %0b want %0b", out_valid, m_valid);
    end
    checks++;
    if (md_busy !== (m_busy_left != 0)) begin
      errors++;
      $display("FAIL md_busy got %0b want %0b", md_busy, (m_busy_left != 0));
    end
    if (m_valid) begin
      checks++;
      if (dut_ctrl() !== m_ctrl) begin
        errors++;
        $display("FAIL bundle instr=%08h got %04h want %04h", m_instr, dut_ctrl(), m_ctrl);
      end
      checks++;
      if (out_instr !== m_instr) begin
        errors++;
        $display("FAIL out_instr got %08h want %08h", out_instr, m_instr);
      end
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    m_valid   = 1'b0;
    m_ctrl    = '0;
    m_instr   = 32'd0;
    m_busy_left = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++;
    if (dut_ctrl() !== '0) begin errors++; $display("FAIL reset_ctrl got %04h want 0", dut_ctrl()); end
    checks++;
    if (out_instr !== 32'd0) begin errors++; $display("FAIL reset_out_instr got %08h want 0", out_instr); end
    checks++;
    if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy got %0b want 0", md_busy); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_jump();
    step(1'b1, 32'h08000c32, 1'b1);  // j
    checks++;
    if ({branch_jump, npc_sel, reg_write} !== {1'b1, 3'd2, 1'b0}) begin
      errors++; $display("FAIL jump_j got %b want 1_010_0", {branch_jump, npc_sel, reg_write});
    end
    step(1'b1, 32'h0c000c32, 1'b1);  // jal
    checks++;
    if ({branch_jump, npc_sel, wa_sel, wd_sel, reg_write} !== {1'b1, 3'd2, 2'd2, 2'd2, 1'b1}) begin
      errors++; $display("FAIL jump_jal got %b", {branch_jump, npc_sel, wa_sel, wd_sel, reg_write});
    end
    step(1'b1, 32'h03e00008, 1'b1);  // jr
    checks++;
    if ({branch_jump, npc_sel, reg_write} !== {1'b1, 3'd3, 1'b0}) begin
      errors++; $display("FAIL jump_jr got %b want 1_011_0", {branch_jump, npc_sel, reg_write});
    end
    step(1'b1, 32'h00400809, 1'b1);  // jalr
    checks++;
    if ({branch_jump, npc_sel, wa_sel, wd_sel} !== {1'b1, 3'd3, 2'd1, 2'd2}) begin
      errors++; $display("FAIL jump_jalr got %b", {branch_jump, npc_sel, wa_sel, wd_sel});
    end
    step(1'b0, 32'd0, 1'b1);
  endtask

  task automatic test_mem_branch();
    step(1'b1, 32'h8c220000, 1'b1);  // lw
    checks++;
    if ({mem_read, wd_sel, wa_sel} !== {1'b1, 2'd1, 2'd0}) begin
      errors++; $display("FAIL mem_lw got %b want 1_01_00", {mem_read, wd_sel, wa_sel});
    end
    step(1'b1, 32'hac220000, 1'b1);  // sw
    checks++;
    if ({mem_write, reg_write} !== 2'b10) begin
      errors++; $display("FAIL mem_sw got %b want 10", {mem_write, reg_write});
    end
    step(1'b1, 32'h10220003, 1'b1);  // beq
    checks++;
    if ({npc_sel, branch_jump} !== {3'd1, 1'b1}) begin
      errors++; $display("FAIL branch_beq got %b want 001_1", {npc_sel, branch_jump});
    end
    step(1'b0, 32'd0, 1'b1);
  endtask

  task automatic test_mult_stall();
    int stalls;
    bit done;
    step(1'b1, 32'h00220018, 1'b1);  // mult
    checks++;
    if (md_start !== 2'b01) begin errors++; $display("FAIL mult_md_start got %b want 01", md_start); end
    stalls = 0;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      step(1'b1, 32'h00001812, 1'b1);  // mflo
      if (obs_ready) done = 1;
      else stalls++;
    end
    checks++;
    if (!done || stalls != MULT_N) begin
      errors++; $display("FAIL mult_stall accepted=%0b stalls got %0d want %0d", done, stalls, MULT_N);
    end
    checks++;
    if (wd_sel !== 2'd3 || out_instr !== 32'h00001812) begin
      errors++; $display("FAIL mflo_bundle wd_sel got %0d want 3 instr %08h", wd_sel, out_instr);
    end
    step(1'b0, 32'd0, 1'b1);
  endtask

  task automatic test_div_traffic();
    int stalls;
    bit done;
    step(1'b1, 32'h0022001a, 1'b1);  // div
    checks++;
    if (md_start !== 2'b10) begin errors++; $display("FAIL div_md_start got %b want 10", md_start); end
    step(1'b1, 32'h8c220000, 1'b1);  // lw during busy
    checks++;
    if (!obs_ready || out_instr !== 32'h8c220000) begin
      errors++; $display("FAIL div_lw_flow ready got %0b instr %08h want 1 8c220000", obs_ready, out_instr);
    end
    stalls = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(1'b1, 32'h00001810, 1'b1);  // mfhi
      if (obs_ready) done = 1;
      else stalls++;
    end
    checks++;
    if (!done || stalls != DIV_N - 1) begin
      errors++; $display("FAIL div_mfhi_stall accepted=%0b stalls got %0d want %0d", done, stalls, DIV_N - 1);
    end
    step(1'b0, 32'd0, 1'b1);
  endtask

  task automatic test_backpressure_reset();
    step(1'b1, 32'h00220018, 1'b1);  // mult
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h00221821, 1'b0);  // addu offered while execute stalls
      checks++;
      if (obs_ready !== 1'b0 || out_instr !== 32'h00220018 || md_start !== 2'b01) begin
        errors++;
        $display("FAIL bp_hold ready got %0b instr %08h md %b want 0 00220018 01", obs_ready, out_instr, md_start);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || md_busy !== 1'b0) begin
      errors++; $display("FAIL async_reset valid %0b busy %0b want 0 0", out_valid, md_busy);
    end
    in_valid  = 1'b0;
    in_instr  = 32'h00001812;  // pending mflo no longer stalled
    m_valid   = 1'b0;
    m_ctrl    = '0;
    m_instr   = 32'd0;
    m_busy_left = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %0b want 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_illegal();
    step(1'b1, 32'hfc000000, 1'b1);
    checks++;
    if (illegal !== 1'b1 || out_valid !== 1'b1 ||
        {branch_jump, npc_sel, reg_write, mem_read, mem_write, wa_sel, wd_sel, md_start} !== 13'd0) begin
      errors++; $display("FAIL illegal_word got %04h valid %0b want 0001 1", dut_ctrl(), out_valid);
    end
    step(1'b0, 32'd0, 1'b1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fn_tab [10];
    logic [5:0] op_tab [5];
    int k;
    fn_tab = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h08, 6'h09, 6'h18, 6'h1a, 6'h10, 6'h12};
    op_tab = '{6'h23, 6'h2b, 6'h04, 6'h02, 6'h03};
    k = $urandom_range(0, 9);
    if (k < 5)
      return {6'h00, 15'($urandom()), 5'd0, fn_tab[$urandom_range(0, 9)]};
    else if (k < 9)
      return {op_tab[$urandom_range(0, 4)], 26'($urandom())};
    else
      return $urandom();
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 3) != 0));
    end
    step(1'b0, 32'd0, 1'b1);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_jump();
    test_mem_branch();
    test_mult_stall();
    test_div_traffic();
    test_backpressure_reset();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
